// File: rtl/reg_array.sv
// 32-entry general-purpose register file; r0 is hardwired to zero.
// Each of r1..r31 is an enable-gated register with synchronous clear.

module reg_elem #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // resetn is active-high: a 1 clears the register
    always_ff @(posedge clk) begin
        if (resetn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module reg_array #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] G,
    input  logic [31:0]  R_in,
    output logic [N-1:0] r0,
    output logic [N-1:0] r1,
    output logic [N-1:0] r2,
    output logic [N-1:0] r3,
    output logic [N-1:0] r4,
    output logic [N-1:0] r5,
    output logic [N-1:0] r6,
    output logic [N-1:0] r7,
    output logic [N-1:0] r8,
    output logic [N-1:0] r9,
    output logic [N-1:0] r10,
    output logic [N-1:0] r11,
    output logic [N-1:0] r12,
    output logic [N-1:0] r13,
    output logic [N-1:0] r14,
    output logic [N-1:0] r15,
    output logic [N-1:0] r16,
    output logic [N-1:0] r17,
    output logic [N-1:0] r18,
    output logic [N-1:0] r19,
    output logic [N-1:0] r20,
    output logic [N-1:0] r21,
    output logic [N-1:0] r22,
    output logic [N-1:0] r23,
    output logic [N-1:0] r24,
    output logic [N-1:0] r25,
    output logic [N-1:0] r26,
    output logic [N-1:0] r27,
    output logic [N-1:0] r28,
    output logic [N-1:0] r29,
    output logic [N-1:0] r30,
    output logic [N-1:0] r31
);

    logic [N-1:0] q [1:31];
    logic         unused_en0;

    // R_in[0] has no register behind it
    assign unused_en0 = R_in[0];

    for (genvar i = 1; i < 32; i++) begin : g_reg
        reg_elem #(.N(N)) u_reg (
            .clk    (clk),
            .resetn (resetn),
            .en     (R_in[i]),
            .d      (G),
            .q      (q[i])
        );
    end

    assign r0  = '0;
    assign r1  = q[1];
    assign r2  = q[2];
    assign r3  = q[3];
    assign r4  = q[4];
    assign r5  = q[5];
    assign r6  = q[6];
    assign r7  = q[7];
    assign r8  = q[8];
    assign r9  = q[9];
    assign r10 = q[10];
    assign r11 = q[11];
    assign r12 = q[12];
    assign r13 = q[13];
    assign r14 = q[14];
    assign r15 = q[15];
    assign r16 = q[16];
    assign r17 = q[17];
    assign r18 = q[18];
    assign r19 = q[19];
    assign r20 = q[20];
    assign r21 = q[21];
    assign r22 = q[22];
    assign r23 = q[23];
    assign r24 = q[24];
    assign r25 = q[25];
    assign r26 = q[26];
    assign r27 = q[27];
    assign r28 = q[28];
    assign r29 = q[29];
    assign r30 = q[30];
    assign r31 = q[31];

endmodule

// File: tb/tb_reg_array.sv
// Bench for reg_array: directed cases then random traffic
// against an array model of the 32 architectural registers.

module tb_reg_array;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] G;
    logic [31:0] R_in;
    logic [31:0] r [32];

    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    reg_array #(.N(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .G      (G),
        .R_in   (R_in),
        .r0  (r[0]),  .r1  (r[1]),  .r2  (r[2]),  .r3  (r[3]),
        .r4  (r[4]),  .r5  (r[5]),  .r6  (r[6]),  .r7  (r[7]),
        .r8  (r[8]),  .r9  (r[9]),  .r10 (r[10]), .r11 (r[11]),
        .r12 (r[12]), .r13 (r[13]), .r14 (r[14]), .r15 (r[15]),
        .r16 (r[16]), .r17 (r[17]), .r18 (r[18]), .r19 (r[19]),
        .r20 (r[20]), .r21 (r[21]), .r22 (r[22]), .r23 (r[23]),
        .r24 (r[24]), .r25 (r[25]), .r26 (r[26]), .r27 (r[27]),
        .r28 (r[28]), .r29 (r[29]), .r30 (r[30]), .r31 (r[31])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s r%0d", tag, i), r[i], model[i]);
    endtask

    // Apply one cycle: outputs must not move before the edge,
    // then must match the architectural model after it.
    task automatic step(input string tag, input logic rst,
                        input logic [31:0] en, input logic [31:0] g,
                        input bit pre_check);
        @(negedge clk);
        resetn = rst;
        R_in   = en;
        G      = g;
        #1;
        if (pre_check) check_all({tag, " pre"});
        @(posedge clk);
        for (int i = 1; i < 32; i++) begin
            if (rst) model[i] = 32'h0;
            else if (en[i]) model[i] = g;
        end
        model[0] = 32'h0;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] en;
        logic [31:0] g;
        logic        rst;

        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        resetn = 1'b0;
        R_in   = 32'h0;
        G      = 32'h0;

        step("reset", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step("single", 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b1);
        check("single r5 const", r[5], 32'hDEAD_BEEF);
        step("hold", 1'b0, 32'h0, 32'h1234_5678, 1'b1);
        check("hold r5 const", r[5], 32'hDEAD_BEEF);
        step("r0 write", 1'b0, 32'h0000_0001, 32'hCAFE_F00D, 1'b1);
        check("r0 const", r[0], 32'h0);
        step("multi", 1'b0, 32'h8000_0006, 32'h0000_ABCD, 1'b1);
        check("multi r31 const", r[31], 32'h0000_ABCD);
        step("load r7", 1'b0, 32'h0000_0080, 32'h0000_0042, 1'b1);
        check("load r7 const", r[7], 32'h0000_0042);
        step("rst wins", 1'b1, 32'h0000_0080, 32'h0000_0099, 1'b1);
        check("rst wins r7 const", r[7], 32'h0);

        for (int i = 1; i < 32; i++)
            step($sformatf("walk%0d", i), 1'b0, 32'h1 << i,
                 i * 32'h0101_0101, 1'b0);
        for (int i = 0; i < 32; i++)
            check($sformatf("walk const r%0d", i), r[i],
                  i * 32'h0101_0101);

        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: en = 32'h1 << $urandom_range(0, 31);
                1: en = 32'h0;
                default: en = $urandom;
            endcase
            g = $urandom;
            step($sformatf("rand%0d", n), rst, en, g, (n % 8) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
